// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: fetches NUM_SPRITES descriptors (x, y, frame) from system RAM once per frame,
// then resolves the lowest-index sprite under the beam and emits a registered glyph ROM address.
// Optional macro SPRITE_MIRROR_EN: frame-word bit SYS_DATA_WIDTH-2 becomes a per-sprite horizontal flip.
module sprite_addr_gen #(
  parameter int                        NUM_SPRITES      = 4,
  parameter int                        SYS_DATA_WIDTH   = 18,
  parameter int                        SYS_ADDR_WIDTH   = 16,
  parameter int                        GLYPH_ADDR_WIDTH = 16,
  parameter int                        LOG2_GLYPH_W     = 5,
  parameter int                        LOG2_GLYPH_H     = 5,
  parameter logic [SYS_ADDR_WIDTH-1:0] DESC_BASE        = 16'h00C8,
  parameter int                        H_OFFSET         = 158
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bright,
  input  logic                        vsync,
  input  logic [9:0]                  hcount,
  input  logic [9:0]                  vcount,
  input  logic [SYS_DATA_WIDTH-1:0]   sys_data,
  output logic [SYS_ADDR_WIDTH-1:0]   sys_addr,
  output logic [GLYPH_ADDR_WIDTH-1:0] glyph_addr,
  output logic                        pix_en,
  output logic [3:0]                  sprite_id,
  output logic                        fetch_done
);

  localparam int NWORDS  = 3 * NUM_SPRITES;
  localparam int IDX_W   = 6;
  localparam int GLYPH_W = 1 << LOG2_GLYPH_W;
  localparam int GLYPH_H = 1 << LOG2_GLYPH_H;
  localparam int SHIFT   = LOG2_GLYPH_W + LOG2_GLYPH_H;
`ifdef SPRITE_MIRROR_EN
  localparam int FRAME_W = SYS_DATA_WIDTH - 2;
`else
  localparam int FRAME_W = SYS_DATA_WIDTH - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {WAIT_VS, FETCH, LAST, RUN} state_t;

  // Sequencer state
  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        vs_q;
  logic [SYS_ADDR_WIDTH-1:0]   sys_addr_q, sys_addr_d;
  logic                        fetch_done_q, fetch_done_d;

  // Shadow words being fetched, and the committed descriptor set used for lookup
  logic [SYS_DATA_WIDTH-1:0]   shd_q [NWORDS];
  logic [SYS_DATA_WIDTH-1:0]   shd_d [NWORDS];
  logic [9:0]                  act_x_q [NUM_SPRITES];
  logic [9:0]                  act_x_d [NUM_SPRITES];
  logic [9:0]                  act_y_q [NUM_SPRITES];
  logic [9:0]                  act_y_d [NUM_SPRITES];
  logic [FRAME_W-1:0]          act_frame_q [NUM_SPRITES];
  logic [FRAME_W-1:0]          act_frame_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]      act_en_q, act_en_d;
`ifdef SPRITE_MIRROR_EN
  logic [NUM_SPRITES-1:0]      act_flip_q, act_flip_d;
`endif

  // Pixel lookup
  logic [10:0]                 px, py;
  logic [LOG2_GLYPH_W-1:0]     xoff;
  logic [LOG2_GLYPH_H-1:0]     yoff;
  logic                        hit_any;
  logic [3:0]                  hit_id;
  logic [GLYPH_ADDR_WIDTH-1:0] hit_addr;
  logic                        pix_en_q, pix_en_d;
  logic [3:0]                  sprite_id_q, sprite_id_d;
  logic [GLYPH_ADDR_WIDTH-1:0] glyph_addr_q, glyph_addr_d;

  logic vs_rise;
  assign vs_rise = vsync & ~vs_q;

  // Fetch sequencer: walk the descriptor table, capture words one cycle behind the address,
  // commit the whole shadow set atomically in LAST; a vsync drop abandons the partial set.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fetch_done_d = 1'b0;
    shd_d        = shd_q;
    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    act_frame_d  = act_frame_q;
    act_en_d     = act_en_q;
`ifdef SPRITE_MIRROR_EN
    act_flip_d   = act_flip_q;
`endif
    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (!vsync) begin
          state_d = WAIT_VS;
        end else begin
          for (int w = 0; w < NWORDS; w++) begin
            if (idx_q != '0 && int'(idx_q) == w + 1) shd_d[w] = sys_data;
          end
          if (idx_q == LAST_IDX) state_d = LAST;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      LAST: begin
        if (!vsync) begin
          state_d = WAIT_VS;
        end else begin
          shd_d[NWORDS-1] = sys_data;
          for (int k = 0; k < NUM_SPRITES; k++) begin
            act_x_d[k]     = shd_d[3*k][9:0];
            act_y_d[k]     = shd_d[3*k+1][9:0];
            act_en_d[k]    = ~shd_d[3*k+2][SYS_DATA_WIDTH-1];
            act_frame_d[k] = shd_d[3*k+2][FRAME_W-1:0];
`ifdef SPRITE_MIRROR_EN
            act_flip_d[k]  = shd_d[3*k+2][SYS_DATA_WIDTH-2];
`endif
          end
          fetch_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: begin
        if (!vsync) state_d = WAIT_VS;
      end
    endcase
    // Address is registered from next-state so it lines up with idx in each FETCH cycle
    sys_addr_d = (state_d == FETCH) ? DESC_BASE + SYS_ADDR_WIDTH'(idx_d) : DESC_BASE;
  end

  // Beam position in sprite space; 11-bit zero-extended so left-of-screen hcount wraps far away
  assign px = 11'({1'b0, hcount}) - 11'(H_OFFSET);
  assign py = {1'b0, vcount};

  // Hit test for every sprite; descending scan so the lowest hitting index is the last write
  always_comb begin
    hit_any  = 1'b0;
    hit_id   = '0;
    hit_addr = '0;
    xoff     = '0;
    yoff     = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (act_en_q[k] &&
          px >= {1'b0, act_x_q[k]} && px < ({1'b0, act_x_q[k]} + 11'(GLYPH_W)) &&
          py >= {1'b0, act_y_q[k]} && py < ({1'b0, act_y_q[k]} + 11'(GLYPH_H))) begin
        xoff = px[LOG2_GLYPH_W-1:0] - act_x_q[k][LOG2_GLYPH_W-1:0];
`ifdef SPRITE_MIRROR_EN
        if (act_flip_q[k]) xoff = LOG2_GLYPH_W'(GLYPH_W - 1) - xoff;
`endif
        yoff     = py[LOG2_GLYPH_H-1:0] - act_y_q[k][LOG2_GLYPH_H-1:0];
        hit_any  = 1'b1;
        hit_id   = 4'(k);
        hit_addr = GLYPH_ADDR_WIDTH'({act_frame_q[k], {SHIFT{1'b0}}}) + GLYPH_ADDR_WIDTH'({yoff, xoff});
      end
    end
  end

  // Output stage: glyph_addr holds its last value whenever no sprite pixel is shown
  always_comb begin
    pix_en_d     = 1'b0;
    sprite_id_d  = '0;
    glyph_addr_d = glyph_addr_q;
    if (state_q == RUN && bright && hit_any) begin
      pix_en_d     = 1'b1;
      sprite_id_d  = hit_id;
      glyph_addr_d = hit_addr;
    end
  end

  // State, descriptor and output registers; vs_q resets high so no fetch starts until vsync is seen low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_VS;
      idx_q        <= '0;
      vs_q         <= 1'b1;
      sys_addr_q   <= DESC_BASE;
      fetch_done_q <= 1'b0;
      for (int w = 0; w < NWORDS; w++) shd_q[w] <= '0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        act_x_q[k]     <= '0;
        act_y_q[k]     <= '0;
        act_frame_q[k] <= '0;
      end
      act_en_q     <= '0;
`ifdef SPRITE_MIRROR_EN
      act_flip_q   <= '0;
`endif
      pix_en_q     <= 1'b0;
      sprite_id_q  <= '0;
      glyph_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vs_q         <= vsync;
      sys_addr_q   <= sys_addr_d;
      fetch_done_q <= fetch_done_d;
      shd_q        <= shd_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      act_frame_q  <= act_frame_d;
      act_en_q     <= act_en_d;
`ifdef SPRITE_MIRROR_EN
      act_flip_q   <= act_flip_d;
`endif
      pix_en_q     <= pix_en_d;
      sprite_id_q  <= sprite_id_d;
      glyph_addr_q <= glyph_addr_d;
    end
  end

  assign sys_addr   = sys_addr_q;
  assign fetch_done = fetch_done_q;
  assign pix_en     = pix_en_q;
  assign sprite_id  = sprite_id_q;
  assign glyph_addr = glyph_addr_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen: fetch sequencing, hit/priority/clip, abort, reset, mirror.
module tb_sprite_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        bright;
  logic        vsync;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [17:0] sys_data;
  logic [15:0] sys_addr;
  logic [15:0] glyph_addr;
  logic        pix_en;
  logic [3:0]  sprite_id;
  logic        fetch_done;

  int checks   = 0;
  int failures = 0;

  logic [17:0] ram [0:65535];
  localparam logic [17:0] DIS = 18'h20000;

  always #5 clk = ~clk;

  // System RAM port B: one-cycle read latency
  always @(posedge clk) sys_data <= ram[sys_addr];

  sprite_addr_gen dut (
    .clk        (clk),
    .reset      (reset),
    .bright     (bright),
    .vsync      (vsync),
    .hcount     (hcount),
    .vcount     (vcount),
    .sys_data   (sys_data),
    .sys_addr   (sys_addr),
    .glyph_addr (glyph_addr),
    .pix_en     (pix_en),
    .sprite_id  (sprite_id),
    .fetch_done (fetch_done)
  );

  task automatic set_sprite(input int k, input int x, input int y, input logic [17:0] fw);
    ram[200 + 3*k]     = 18'(x);
    ram[200 + 3*k + 1] = 18'(y);
    ram[200 + 3*k + 2] = fw;
  endtask

  // Drive a beam position at a falling edge; outputs for it are visible at the next falling edge
  task automatic pix(input int x, input int y, input logic br);
    hcount = 10'(x + 158);
    vcount = 10'(y);
    bright = br;
    @(negedge clk);
  endtask

  task automatic refetch();
    int n;
    n = 0;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    while (fetch_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (fetch_done !== 1'b1) begin $display("FAIL refetch_timeout fetch_done=%0b after %0d cycles, required 1", fetch_done, n); failures++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b0; bright = 1'b0; hcount = '0; vcount = '0;
    repeat (2) @(negedge clk);
    checks++; if (glyph_addr !== 16'd0) begin $display("FAIL reset_glyph_addr got=%0d exp=0", glyph_addr); failures++; end
    checks++; if (pix_en !== 1'b0) begin $display("FAIL reset_pix_en got=%0b exp=0", pix_en); failures++; end
    checks++; if (sprite_id !== 4'd0) begin $display("FAIL reset_sprite_id got=%0d exp=0", sprite_id); failures++; end
    checks++; if (sys_addr !== 16'h00C8) begin $display("FAIL reset_sys_addr got=%h exp=00c8", sys_addr); failures++; end
    checks++; if (fetch_done !== 1'b0) begin $display("FAIL reset_fetch_done got=%0b exp=0", fetch_done); failures++; end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [15:0] exp_a;
    set_sprite(0, 100, 50, 18'd2);
    set_sprite(1, 0, 0, DIS);
    set_sprite(2, 0, 0, DIS);
    set_sprite(3, 0, 0, DIS);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_a = 16'h00C8 + 16'(i);
      checks++; if (sys_addr !== exp_a) begin $display("FAIL fetch_addr step=%0d got=%h exp=%h", i, sys_addr, exp_a); failures++; end
      checks++; if (fetch_done !== 1'b0) begin $display("FAIL fetch_done_early step=%0d got=%0b exp=0", i, fetch_done); failures++; end
    end
    @(negedge clk);
    checks++; if (fetch_done !== 1'b0) begin $display("FAIL fetch_done_cycle12 got=%0b exp=0", fetch_done); failures++; end
    checks++; if (sys_addr !== 16'h00C8) begin $display("FAIL fetch_addr_last got=%h exp=00c8", sys_addr); failures++; end
    @(negedge clk);
    checks++; if (fetch_done !== 1'b1) begin $display("FAIL fetch_done_cycle13 got=%0b exp=1", fetch_done); failures++; end
    @(negedge clk);
    checks++; if (fetch_done !== 1'b0) begin $display("FAIL fetch_done_pulse got=%0b exp=0", fetch_done); failures++; end
  endtask

  task automatic test_single_hit();
    pix(105, 53, 1'b1);
    checks++; if (pix_en !== 1'b1 || sprite_id !== 4'd0 || glyph_addr !== 16'd2149) begin $display("FAIL single_hit pix_en=%0b id=%0d addr=%0d exp 1/0/2149", pix_en, sprite_id, glyph_addr); failures++; end
    pix(100, 50, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== 16'd2048) begin $display("FAIL single_topleft pix_en=%0b addr=%0d exp 1/2048", pix_en, glyph_addr); failures++; end
    pix(131, 81, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== 16'd3071) begin $display("FAIL single_botright pix_en=%0b addr=%0d exp 1/3071", pix_en, glyph_addr); failures++; end
    pix(132, 81, 1'b1);
    checks++; if (pix_en !== 1'b0 || sprite_id !== 4'd0 || glyph_addr !== 16'd3071) begin $display("FAIL single_right_miss pix_en=%0b id=%0d addr=%0d exp 0/0/3071", pix_en, sprite_id, glyph_addr); failures++; end
    pix(131, 82, 1'b1);
    checks++; if (pix_en !== 1'b0) begin $display("FAIL single_bottom_miss pix_en=%0b exp 0", pix_en); failures++; end
  endtask

  task automatic test_priority();
    set_sprite(0, 0, 0, DIS);
    set_sprite(1, 200, 200, 18'd0);
    set_sprite(2, 200, 200, 18'd0);
    set_sprite(3, 0, 0, DIS);
    refetch();
    pix(210, 201, 1'b1);
    checks++; if (pix_en !== 1'b1 || sprite_id !== 4'd1 || glyph_addr !== 16'd42) begin $display("FAIL prio_low_idx pix_en=%0b id=%0d addr=%0d exp 1/1/42", pix_en, sprite_id, glyph_addr); failures++; end
    set_sprite(1, 200, 200, DIS);
    refetch();
    pix(210, 201, 1'b1);
    checks++; if (pix_en !== 1'b1 || sprite_id !== 4'd2 || glyph_addr !== 16'd42) begin $display("FAIL prio_next_idx pix_en=%0b id=%0d addr=%0d exp 1/2/42", pix_en, sprite_id, glyph_addr); failures++; end
  endtask

  task automatic test_edge_clip();
    set_sprite(0, 620, 0, 18'd1);
    set_sprite(2, 0, 0, DIS);
    refetch();
    pix(639, 5, 1'b1);
    checks++; if (pix_en !== 1'b1 || sprite_id !== 4'd0 || glyph_addr !== 16'd1203) begin $display("FAIL clip_x639 pix_en=%0b id=%0d addr=%0d exp 1/0/1203", pix_en, sprite_id, glyph_addr); failures++; end
    pix(0, 5, 1'b1);
    checks++; if (pix_en !== 1'b0 || glyph_addr !== 16'd1203) begin $display("FAIL clip_x0 pix_en=%0b addr=%0d exp 0/1203", pix_en, glyph_addr); failures++; end
    pix(651, 31, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== 16'd2047) begin $display("FAIL clip_x651 pix_en=%0b addr=%0d exp 1/2047", pix_en, glyph_addr); failures++; end
    pix(652, 5, 1'b1);
    checks++; if (pix_en !== 1'b0) begin $display("FAIL clip_x652 pix_en=%0b exp 0", pix_en); failures++; end
    pix(639, 32, 1'b1);
    checks++; if (pix_en !== 1'b0) begin $display("FAIL clip_y32 pix_en=%0b exp 0", pix_en); failures++; end
    pix(639, 5, 1'b0);
    checks++; if (pix_en !== 1'b0 || sprite_id !== 4'd0) begin $display("FAIL blank pix_en=%0b id=%0d exp 0/0", pix_en, sprite_id); failures++; end
    pix(-100, 5, 1'b1);
    checks++; if (pix_en !== 1'b0) begin $display("FAIL left_of_visible pix_en=%0b exp 0", pix_en); failures++; end
  endtask

  task automatic test_abort();
    bit seen_done;
    bit seen_pix;
    set_sprite(0, 100, 50, 18'd2);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (5) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    checks++; if (sys_addr !== 16'h00C8) begin $display("FAIL abort_addr got=%h exp=00c8", sys_addr); failures++; end
    seen_done = 1'b0;
    seen_pix  = 1'b0;
    hcount = 10'(105 + 158); vcount = 10'd53; bright = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (fetch_done === 1'b1) seen_done = 1'b1;
      if (pix_en === 1'b1) seen_pix = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin $display("FAIL abort_fetch_done seen=%0b exp 0", seen_done); failures++; end
    checks++; if (seen_pix !== 1'b0) begin $display("FAIL abort_pix_en seen=%0b exp 0", seen_pix); failures++; end
    refetch();
    pix(105, 53, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== 16'd2149) begin $display("FAIL abort_recover pix_en=%0b addr=%0d exp 1/2149", pix_en, glyph_addr); failures++; end
  endtask

  task automatic test_mirror();
    logic [15:0] exp_a;
`ifdef SPRITE_MIRROR_EN
    exp_a = 16'd3100;
`else
    exp_a = 16'd3075;
`endif
    set_sprite(0, 100, 50, 18'h10003);
    refetch();
    pix(103, 50, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== exp_a) begin $display("FAIL mirror pix_en=%0b addr=%0d exp 1/%0d", pix_en, glyph_addr, exp_a); failures++; end
  endtask

  task automatic test_reset_in_run();
    bit seen_pix;
    pix(103, 50, 1'b1);
    reset = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    checks++; if (pix_en !== 1'b0 || sprite_id !== 4'd0 || glyph_addr !== 16'd0) begin $display("FAIL run_reset_out pix_en=%0b id=%0d addr=%0d exp 0/0/0", pix_en, sprite_id, glyph_addr); failures++; end
    checks++; if (sys_addr !== 16'h00C8 || fetch_done !== 1'b0) begin $display("FAIL run_reset_seq addr=%h done=%0b exp 00c8/0", sys_addr, fetch_done); failures++; end
    reset = 1'b0;
    seen_pix = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pix_en === 1'b1) seen_pix = 1'b1;
    end
    checks++; if (seen_pix !== 1'b0) begin $display("FAIL run_reset_no_pix seen=%0b exp 0", seen_pix); failures++; end
    set_sprite(0, 100, 50, 18'd2);
    refetch();
    pix(105, 53, 1'b1);
    checks++; if (pix_en !== 1'b1 || glyph_addr !== 16'd2149) begin $display("FAIL run_reset_recover pix_en=%0b addr=%0d exp 1/2149", pix_en, glyph_addr); failures++; end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = '0;
    reset = 1'b1; vsync = 1'b0; bright = 1'b0; hcount = '0; vcount = '0;
    test_reset();
    test_fetch();
    test_single_hit();
    test_priority();
    test_edge_clip();
    test_abort();
    test_mirror();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
